// File: rtl/proj_to_affine.sv
// proj_to_affine: projective (X:Y:Z) to affine (X/Z, Y/Z) over GF(2^255-19), Montgomery domain (R = 2^256)
// Ports: clock, reset_n (async active-low); in_valid/in_ready with in_x/in_y/in_z projective input;
//        out_valid/out_ready with out_x/out_y affine result and out_zinf (input z was 0).
// Optional: X25519_P2A_ONE_BYPASS_EN forwards in_x/in_y straight out when z equals ONE_M.
module proj_to_affine #(
  parameter logic [255:0] P     = 256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED,
  parameter logic [255:0] ONE_M = 256'd38
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_x,
  input  logic [255:0] in_y,
  input  logic [255:0] in_z,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_x,
  output logic [255:0] out_y,
  output logic         out_zinf
);
  typedef enum logic [2:0] {S_IDLE, S_EXP, S_FINX, S_FINY, S_HOLD} state_t;
  // -P^-1 mod 2^256 by Newton iteration; each step doubles the number of correct low bits
  function automatic logic [255:0] neg_inv(input logic [255:0] p);
    logic [255:0] v;
    v = p;
    for (int k = 0; k < 8; k++) v = v * (256'd2 - p * v);
    return -v;
  endfunction
  localparam logic [255:0] P_INV = neg_inv(P);
  localparam logic [255:0] E     = P - 256'd2;
  function automatic logic [255:0] mm(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] t;
    logic [255:0] m;
    logic [512:0] u;
    logic [256:0] s;
    t = {256'd0, a} * {256'd0, b};
    m = t[255:0] * P_INV;
    u = {1'b0, t} + {257'd0, m} * {257'd0, P};
    s = 257'(u >> 256);
    return (s >= {1'b0, P}) ? 256'(s - {1'b0, P}) : s[255:0];
  endfunction
  state_t       r_state;
  logic [255:0] r_x, r_y, r_z, r_acc, r_ox, r_oy;
  logic [7:0]   r_i;
  logic         r_phase, r_in_ready, r_out_valid, r_zinf;
  logic [255:0] w_a, w_b, w_mm;
  logic         w_bypass;
`ifdef X25519_P2A_ONE_BYPASS_EN
  assign w_bypass = r_z == ONE_M;
`else
  assign w_bypass = 1'b0;
`endif
  // one shared multiplier: SQR acc*acc, MUL acc*z, FINX x*acc, FINY y*acc
  always_comb begin
    w_a  = (r_state == S_FINX) ? r_x : (r_state == S_FINY) ? r_y : r_acc;
    w_b  = (r_state == S_EXP && r_phase) ? r_z : r_acc;
    w_mm = mm(w_a, w_b);
  end
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_x     = r_ox;
  assign out_y     = r_oy;
  assign out_zinf  = r_zinf;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_acc       <= '0;
      r_ox        <= '0;
      r_oy        <= '0;
      r_i         <= '0;
      r_phase     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_zinf      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_x        <= in_x;
          r_y        <= in_y;
          r_z        <= in_z;
          r_acc      <= ONE_M;
          r_i        <= 8'd254;
          r_phase    <= 1'b0;
          r_in_ready <= 1'b0;
          r_state    <= S_EXP;
        end
        S_EXP: if (w_bypass) begin
          r_ox        <= r_x;
          r_oy        <= r_y;
          r_zinf      <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= S_HOLD;
        end else begin
          r_acc <= w_mm;
          // a set exponent bit inserts a MUL phase before moving to the next bit
          if (!r_phase && E[r_i]) r_phase <= 1'b1;
          else begin
            r_phase <= 1'b0;
            if (r_i == 8'd0) r_state <= S_FINX;
            else r_i <= r_i - 8'd1;
          end
        end
        S_FINX: begin
          r_ox    <= w_mm;
          r_state <= S_FINY;
        end
        S_FINY: begin
          r_oy        <= w_mm;
          r_zinf      <= r_z == 256'd0;
          r_out_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
        S_HOLD: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_proj_to_affine.sv
// tb_proj_to_affine: directed and random checks of proj_to_affine
module tb_proj_to_affine;
  localparam logic [255:0] P = 256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED;
`ifdef X25519_P2A_ONE_BYPASS_EN
  localparam int LAT_ONE = 1;
`else
  localparam int LAT_ONE = 510;
`endif
  logic         clock = 0, reset_n = 0;
  logic         in_valid = 0, in_ready, out_valid, out_ready = 0, out_zinf;
  logic [255:0] in_x = 0, in_y = 0, in_z = 0, out_x, out_y;
  int           checks = 0, errors = 0, lat;
  logic [255:0] hx, hy, rx, ry, rz;
  proj_to_affine dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_zinf(out_zinf)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  // radix-2 bit-serial Montgomery product a*b*2^-256 mod P
  function automatic logic [255:0] mm_ref(input logic [255:0] a, input logic [255:0] b);
    logic [257:0] u;
    u = '0;
    for (int k = 0; k < 256; k++) begin
      if (a[k]) u = u + {2'b0, b};
      if (u[0]) u = u + {2'b0, P};
      u = u >> 1;
    end
    if (u >= {2'b0, P}) u = u - {2'b0, P};
    return u[255:0];
  endfunction
  function automatic logic [255:0] rnd_fe();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    v[255] = 1'b0;
    if (v >= P) v = v - P;
    return v;
  endfunction
  task automatic run(input logic [255:0] x, input logic [255:0] y, input logic [255:0] z, output int l);
    @(negedge clock);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; in_x = x; in_y = y; in_z = z;
    @(posedge clock);
    #1 in_valid = 0;
    l = 0;
    while (!out_valid && l < 1000) begin
      @(posedge clock);
      #1 l++;
    end
    if (!out_valid) chk("timeout", 0, 1);
  endtask
  task automatic retire();
    @(negedge clock);
    out_ready = 1;
    @(posedge clock);
    #1 out_ready = 0;
    chk("valid_drop", out_valid, 0);
    chk("ready_back", in_ready, 1);
  endtask
  initial begin
    #12 reset_n = 1;
    @(negedge clock);
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_x", out_x, 0);
    chk("rst_y", out_y, 0);
    chk("rst_zinf", out_zinf, 0);
    run(190, 266, 38, lat);
    chk("one_lat", 256'(lat), 256'(LAT_ONE));
    chk("one_x", out_x, 190);
    chk("one_y", out_y, 266);
    chk("one_zinf", out_zinf, 0);
    retire();
    run(76, 152, 76, lat);
    chk("two_lat", 256'(lat), 510);
    chk("two_x", out_x, 38);
    chk("two_y", out_y, 76);
    retire();
    run(190, 266, 0, lat);
    chk("inf_lat", 256'(lat), 510);
    chk("inf_x", out_x, 0);
    chk("inf_y", out_y, 0);
    chk("inf_zinf", out_zinf, 1);
    hx = out_x; hy = out_y;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      in_valid = 1; in_x = 76; in_y = 152; in_z = 76;
      chk("bp_valid", out_valid, 1);
      chk("bp_ready", in_ready, 0);
      chk("bp_x", out_x, hx);
      chk("bp_y", out_y, hy);
      chk("bp_zinf", out_zinf, 1);
    end
    @(negedge clock);
    out_ready = 1;
    @(posedge clock);
    #1 out_ready = 0;
    chk("bp_drop", out_valid, 0);
    chk("bp_not_taken", in_ready, 1);
    @(posedge clock);
    #1 in_valid = 0;
    chk("bp_accept", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 1000) begin
      @(posedge clock);
      #1 lat++;
    end
    chk("bp_lat", 256'(lat), 510);
    chk("bp_x2", out_x, 38);
    chk("bp_y2", out_y, 76);
    retire();
    @(negedge clock);
    in_valid = 1; in_x = 190; in_y = 266; in_z = 76;
    @(posedge clock);
    #1 in_valid = 0;
    repeat (200) @(posedge clock);
    #2 reset_n = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    @(negedge clock);
    reset_n = 1;
    run(76, 152, 76, lat);
    chk("arst_lat", 256'(lat), 510);
    chk("arst_x", out_x, 38);
    chk("arst_y", out_y, 76);
    retire();
    for (int n = 0; n < 30; n++) begin
      rx = rnd_fe(); ry = rnd_fe(); rz = rnd_fe();
      if (rz == 0) rz = 1;
      run(rx, ry, rz, lat);
      chk("rnd_x", mm_ref(out_x, rz), rx);
      chk("rnd_y", mm_ref(out_y, rz), ry);
      chk("rnd_x_lt_p", out_x < P, 1);
      chk("rnd_y_lt_p", out_y < P, 1);
      retire();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
